// File: rtl/contador_if.sv
// contador_if: direction input and count/flag outputs of the contador up/down counter.
// The master side drives ud; the slave side (the counter) drives cont and the decoded flags.
interface contador_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ud;
    logic [WIDTH-1:0] cont;
    logic             zero;
    logic             max;
    logic             tc;

    modport master (
        output ud,
        input  cont,
        input  zero,
        input  max,
        input  tc
    );

    modport slave (
        input  ud,
        output cont,
        output zero,
        output max,
        output tc
    );
endinterface

// File: rtl/contador.sv
// contador: WIDTH-bit up/down counter, one-cycle latency, free-running (no backpressure).
// Define CONTADOR_SATURATE_EN to hold at 0 / all-ones instead of wrapping modulo 2^WIDTH.
module contador #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    contador_if.slave  bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cont_q;
    logic [WIDTH-1:0] cont_d;
    logic             zero_w;
    logic             max_w;

    always_comb begin
        zero_w = (cont_q == '0);
        max_w  = (cont_q == ALL_ONES);
    end

    // Reset is applied in the register process, so cont_d only covers counting.
    always_comb begin
        cont_d = cont_q;
`ifdef CONTADOR_SATURATE_EN
        if (bus.ud) begin
            cont_d = max_w ? cont_q : cont_q + ONE;
        end else begin
            cont_d = zero_w ? cont_q : cont_q - ONE;
        end
`else
        if (bus.ud) begin
            cont_d = cont_q + ONE;
        end else begin
            cont_d = cont_q - ONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    // Flags are pure decodes of the register and the live direction input.
    always_comb begin
        bus.cont = cont_q;
        bus.zero = zero_w;
        bus.max  = max_w;
        bus.tc   = (bus.ud & max_w) | (~bus.ud & zero_w);
    end
endmodule

// File: tb/tb_contador.sv
// tb_contador: vector table, spec-plan sequences and randomized run against an integer model.
module tb_contador;
    localparam int W    = 8;
    localparam int MOD  = 1 << W;
    localparam int MAXV = MOD - 1;
`ifdef CONTADOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;

    contador_if #(.WIDTH(W)) bus ();

    contador #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_err;

    typedef struct {
        logic rst;
        logic ud;
        int   cont;
        logic zero;
        logic max;
        logic tc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the count, flags from their definitions.
    int m;

    task automatic model_edge(input logic r, input logic u);
        if (r) m = 0;
        else if (u) m = SAT ? ((m == MAXV) ? MAXV : m + 1) : (m + 1) % MOD;
        else        m = SAT ? ((m == 0) ? 0 : m - 1) : (m + MOD - 1) % MOD;
    endtask

    task automatic chk_all(input string tag, input logic u);
        chk({tag, "_cont"}, int'(bus.cont), m);
        chk({tag, "_zero"}, int'(bus.zero), int'(m == 0));
        chk({tag, "_max"},  int'(bus.max),  int'(m == MAXV));
        chk({tag, "_tc"},   int'(bus.tc),   int'(u ? (m == MAXV) : (m == 0)));
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        bus.ud = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1};
`ifdef CONTADOR_SATURATE_EN
        vecs[6] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
`else
        vecs[6] = '{1'b0, 1'b0, 255, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
`endif
        vecs[9] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1};

        // Reset state, and tc following ud while held in reset.
        step();
        chk("rst_cont", int'(bus.cont), 0);
        chk("rst_zero", int'(bus.zero), 1);
        chk("rst_max",  int'(bus.max),  0);
        chk("rst_tc_ud0", int'(bus.tc), 1);
        bus.ud = 1'b1;
        #1;
        chk("rst_tc_ud1", int'(bus.tc), 0);

        for (int i = 0; i < 10; i++) begin
            rst    = vecs[i].rst;
            bus.ud = vecs[i].ud;
            step();
            chk($sformatf("vec%0d_cont", i), int'(bus.cont), vecs[i].cont);
            chk($sformatf("vec%0d_zero", i), int'(bus.zero), int'(vecs[i].zero));
            chk($sformatf("vec%0d_max", i),  int'(bus.max),  int'(vecs[i].max));
            chk($sformatf("vec%0d_tc", i),   int'(bus.tc),   int'(vecs[i].tc));
        end

`ifndef CONTADOR_SATURATE_EN
        // Full up sweep and wrap.
        rst = 1'b1; bus.ud = 1'b1; step(); rst = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            step();
            chk("up_sweep", int'(bus.cont), i);
        end
        chk("up_max", int'(bus.max), 1);
        chk("up_tc",  int'(bus.tc),  1);
        step();
        chk("up_wrap_cont", int'(bus.cont), 0);
        chk("up_wrap_zero", int'(bus.zero), 1);

        // Full down sweep and wrap.
        rst = 1'b1; bus.ud = 1'b0; step(); rst = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            step();
            chk("down_sweep", int'(bus.cont), 256 - i);
        end
        step();
        chk("down_zero_cont", int'(bus.cont), 0);
        chk("down_zero_tc",   int'(bus.tc),   1);
        step();
        chk("down_wrap_cont", int'(bus.cont), 255);
`else
        rst = 1'b1; bus.ud = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 300; i++) step();
        chk("sat_up_cont", int'(bus.cont), 255);
        chk("sat_up_tc",   int'(bus.tc),   1);
        bus.ud = 1'b0;
        for (int i = 0; i < 300; i++) step();
        chk("sat_dn_cont", int'(bus.cont), 0);
        chk("sat_dn_zero", int'(bus.zero), 1);
        chk("sat_dn_tc",   int'(bus.tc),   1);
`endif

        // Direction reversal: ud flips after edges 100, 150 and 225.
        rst = 1'b1; bus.ud = 1'b1; step(); rst = 1'b0;
        for (int e = 1; e <= 255; e++) begin
            step();
            if (e == 100) chk("rev_e100", int'(bus.cont), 100);
            if (e == 150) chk("rev_e150", int'(bus.cont), 50);
            if (e == 225) chk("rev_e225", int'(bus.cont), 125);
            if (e == 100 || e == 150 || e == 225) bus.ud = ~bus.ud;
        end
        chk("rev_e255", int'(bus.cont), 95);

        // Reset mid-count, resume, and a reset pulse that misses every edge.
        rst = 1'b1; bus.ud = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("mid_pre", int'(bus.cont), 100);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst", int'(bus.cont), 0);
        for (int i = 0; i < 5; i++) step();
        chk("mid_resume", int'(bus.cont), 5);
        rst = 1'b1; #2; rst = 1'b0; #1;
        chk("glitch_hold", int'(bus.cont), 5);
        step();
        chk("glitch_next", int'(bus.cont), 6);

        // Reset wins over a simultaneous direction change.
        rst = 1'b1; bus.ud = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 77; i++) step();
        chk("prio_pre", int'(bus.cont), 77);
        rst = 1'b1; bus.ud = 1'b0; step(); rst = 1'b0;
        chk("prio_rst", int'(bus.cont), 0);

        // Randomized run against the integer model.
        rst = 1'b1; bus.ud = 1'b0; step();
        m = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic u;
            r = ($urandom_range(15) == 0);
            u = 1'($urandom_range(1));
            rst    = r;
            bus.ud = u;
            step();
            model_edge(r, u);
            chk_all("rand", u);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
